mod_counter_sched: RTL and testbench

MOD_COUNTER_SCHED -- requirements
Module: mod_counter_sched

---
 rtl/mod_counter_sched_pkg.sv | 21 ++
 rtl/mod_counter_sched_rr_arbiter.sv | 35 +++
 rtl/mod_counter_sched.sv | 134 +++++++++++++
 tb/tb_mod_counter_sched.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_sched_pkg.sv
// mod_counter_sched_pkg
//   Shared definitions for the modulo-counter scheduler: FSM state
//   encoding, default sizing constants and an index-width helper.
package mod_counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int CW_DEF    = 4;

    // Width of a requester index; never zero so a single requester still
    // gets a legal 1-bit pointer.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_counter_sched_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. The search starts at the requester
//   after 'ptr' and wraps N_REQ-1 -> 0; the last winner has lowest priority.
// Ports:
//   req  - request vector
//   ptr  - index of the previous winner
//   win  - one-hot winner, all zero when nobody requests
module rr_arbiter
    import mod_counter_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win
);

    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester after
    // ptr is the one left standing.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                win      = '0;
                win[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_counter_sched.sv
// mod_counter_sched
//   A single modulo counter shared by N_REQ requesters. An idle scheduler
//   grants the round-robin winner, latches that requester's modulus and
//   round count, and runs q through 0..mod-1 'rounds' times before a
//   one-cycle DONE. Moduli 0 and 1 are rejected with err alongside done.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   req           - level request per requester
//   mod_in/rnd_in - packed per-requester modulus / round count (0 = 2^CW)
//   gnt           - one-hot grant (zero in IDLE)
//   q, tc         - counter value, terminal count while running
//   done, err     - completion pulse to the winner, illegal-modulus pulse
//   busy          - scheduler not idle
module mod_counter_sched
    import mod_counter_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*CW-1:0]   mod_in,
    input  logic [N_REQ*CW-1:0]   rnd_in,
    output logic [N_REQ-1:0]      gnt,
    output logic [CW-1:0]         q,
    output logic                  tc,
    output logic [N_REQ-1:0]      done,
    output logic                  err,
    output logic                  busy
);

    localparam int IW = idx_w(N_REQ);

    typedef struct packed {
        logic [CW-1:0] modv;
        logic [CW-1:0] rnd;   // rounds left; 0 stands for 2^CW
    } job_t;

    state_t          st;
    job_t            job;
    logic [IW-1:0]   ptr;
    logic [N_REQ-1:0] win;
    logic [IW-1:0]   win_idx;
    job_t            sel;
    logic            last_q;
    logic            illegal;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

    // Winner index and its job slices.
    always_comb begin
        win_idx  = '0;
        sel      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_idx  = IW'(i);
                sel.modv = mod_in[i*CW +: CW];
                sel.rnd  = rnd_in[i*CW +: CW];
            end
        end
    end

    assign illegal = (sel.modv <= CW'(1));
    assign last_q  = (q == job.modv - CW'(1));
    assign tc      = (st == RUN) && last_q;
    assign busy    = (st != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= IDLE;
            gnt  <= '0;
            q    <= '0;
            done <= '0;
            err  <= '0;
            job  <= '0;
            ptr  <= IW'(N_REQ - 1);
        end else begin
            done <= '0;
            err  <= '0;
            unique case (st)
                IDLE: begin
                    if (|req) begin
                        gnt <= win;
                        q   <= '0;
                        job <= sel;
                        ptr <= win_idx;
                        if (illegal) begin
                            st   <= DONE;
                            done <= win;
                            err  <= 1'b1;
                        end else begin
                            st <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Winner dropped its request: abandon silently.
                    if (!(|(req & gnt))) begin
                        st  <= IDLE;
                        q   <= '0;
                        gnt <= '0;
                    end else if (last_q) begin
                        q <= '0;
                        // rnd wraps 0 -> all-ones, so 0 naturally yields 2^CW rounds.
                        if (job.rnd == CW'(1)) begin
                            st   <= DONE;
                            done <= gnt;
                        end else begin
                            job.rnd <= job.rnd - CW'(1);
                        end
                    end else begin
                        q <= q + CW'(1);
                    end
                end
                DONE: begin
                    st  <= IDLE;
                    gnt <= '0;
                    q   <= '0;
                end
                default: begin
                    st  <= IDLE;
                    gnt <= '0;
                    q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_counter_sched.sv
// tb_mod_counter_sched
//   Scoreboard bench: the stimulus thread predicts each job's visible cycles
//   from the scheduling rules and queues them; a monitor pops one entry for
//   every cycle the DUT shows activity.
module tb_mod_counter_sched;

    localparam int N  = 4;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*CW-1:0]   mod_in = '0;
    logic [N*CW-1:0]   rnd_in = '0;
    logic [N-1:0]      gnt;
    logic [CW-1:0]     q;
    logic              tc;
    logic [N-1:0]      done;
    logic              err;
    logic              busy;

    mod_counter_sched #(.N_REQ(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .mod_in(mod_in), .rnd_in(rnd_in),
        .gnt(gnt), .q(q), .tc(tc), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [CW-1:0] q;
        logic          tc;
        logic [N-1:0]  done;
        logic          err;
        logic          busy;
    } obs_t;

    obs_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ptr   = N - 1;   // model of the last winner

    function automatic int pick(input logic [N-1:0] r);
        for (int o = 1; o <= N; o++) begin
            int i;
            i = (ptr + o) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic void push(input int w, input int qq, input bit t,
                                 input bit d, input bit e);
        obs_t o;
        o.gnt  = N'(1) << w;
        o.q    = CW'(qq);
        o.tc   = t;
        o.done = d ? (N'(1) << w) : '0;
        o.err  = e;
        o.busy = 1'b1;
        expq.push_back(o);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: any visible activity must match the next predicted cycle.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            a = '{gnt: gnt, q: q, tc: tc, done: done, err: err, busy: busy};
            if (busy || gnt != '0 || done != '0 || err || tc || q != '0) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_cycle: got %h expected no activity", a);
                end else begin
                    e = expq.pop_front();
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL cycle: got gnt=%b q=%0d tc=%b done=%b err=%b busy=%b expected gnt=%b q=%0d tc=%b done=%b err=%b busy=%b",
                                 a.gnt, a.q, a.tc, a.done, a.err, a.busy,
                                 e.gnt, e.q, e.tc, e.done, e.err, e.busy);
                    end
                end
            end
        end
    end

    // Entered at an IDLE cycle; returns at the next IDLE cycle.
    task automatic job(input logic [N-1:0] r, input logic [N*CW-1:0] m,
                       input logic [N*CW-1:0] rn, input int abort_at, input bit rel);
        int w, md, rd, len;
        req = r; mod_in = m; rnd_in = rn;
        w  = pick(r);
        md = int'(m[w*CW +: CW]);
        rd = int'(rn[w*CW +: CW]);
        if (rd == 0) rd = 1 << CW;
        ptr = w;
        len = (md < 2) ? 0 : md * rd;
        if (md >= 2 && abort_at >= 0 && abort_at < len) begin
            for (int k = 0; k <= abort_at; k++) push(w, k % md, (k % md) == md - 1, 0, 0);
            tick();
            mod_in = (N*CW)'($urandom); rnd_in = (N*CW)'($urandom);
            repeat (abort_at) tick();
            req[w] = 1'b0;
            if (rel) req = '0;
            tick();
            return;
        end
        for (int k = 0; k < len; k++) push(w, k % md, (k % md) == md - 1, 0, 0);
        push(w, 0, 0, 1, md < 2);
        tick();
        mod_in = (N*CW)'($urandom); rnd_in = (N*CW)'($urandom);
        repeat (len) tick();
        if (rel) req = '0;
        tick();
    endtask

    function automatic logic [N*CW-1:0] fill(input int v);
        logic [N*CW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i*CW +: CW] = CW'(v);
        return p;
    endfunction

    initial begin
        logic [N-1:0] r;
        logic [N*CW-1:0] m, rn;

        // Reset state
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_flags", {28'd0, tc, err, busy, |done}, 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Single job mod 13, one round
        job(4'b0001, fill(13), fill(1), -1, 1);
        // Round-robin with all requesters held
        for (int j = 0; j < 5; j++) job(4'b1111, fill(3), fill(1), -1, j == 4);
        // 16 rounds of mod 5
        job(4'b0001, fill(5), fill(0), -1, 1);
        // Illegal moduli 1 and 0
        job(4'b0001, fill(1), fill(1), -1, 1);
        job(4'b0100, fill(0), fill(2), -1, 1);
        // Abort: set pointer to 1, then requester 2 aborts at q=4; 3 follows
        job(4'b0010, fill(2), fill(1), -1, 1);
        job(4'b1100, fill(10), fill(1), 4, 0);
        job(4'b1000, fill(2), fill(2), -1, 1);

        // Reset mid-RUN at q=7
        req = 4'b0001; mod_in = fill(12); rnd_in = fill(1);
        for (int k = 0; k <= 7; k++) push(0, k, 0, 0, 0);
        ptr = 0;
        repeat (8) tick();
        chk("pre_rst_q", 32'(q), 7);
        rst = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_q", 32'(q), 0);
        chk("midrst_busy_done", {30'd0, busy, |done}, 0);
        ptr = N - 1;
        req = '0;
        tick();
        rst = 1'b1;
        job(4'b1111, fill(4), fill(1), -1, 1);

        // Randomized jobs
        for (int j = 0; j < 25; j++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                m[i*CW +: CW]  = CW'($urandom_range(0, 15));
                rn[i*CW +: CW] = CW'($urandom_range(0, 3));
            end
            job(r, m, rn, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : -1,
                $urandom_range(0, 1) == 1);
        end
        req = '0;
        repeat (3) tick();
        chk("queue_drained", 32'(expq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
